// File: rtl/wb_gpio_poller.sv
// wb_gpio_poller
//   Wishbone initiator that periodically reads a GPIO responder's input-data
//   register, keeps a shadow copy of the pin state, flags changed bits and
//   raises a masked one-cycle interrupt. A valid/ready command port forwards
//   writes to the responder's output (base+1) or direction (base+2) register.
//
//   Optional feature macro: WB_GPIO_POLLER_TIMEOUT_EN
//     defined   - bus cycles without ack for timeout_cycles clocks are aborted
//                 and err pulses for one cycle.
//     undefined - the initiator waits for ack indefinitely; err is tied 0.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   wb_adr_o/dat_o/we_o/cyc_o/stb_o, wb_dat_i/ack_i   Wishbone initiator side
//   cmd_valid/cmd_ready/cmd_sel/cmd_data               register-write requests
//   irq_mask            per-bit interrupt enable
//   gpio_state          last polled pin value
//   change_mask         bits that changed at the last completed poll
//   irq                 one-cycle pulse on a masked change
//   err                 one-cycle pulse on a bus timeout
module wb_gpio_poller #(
  parameter int gpio_io_width  = 8,
  parameter int wb_dat_width   = 16,
  parameter int wb_adr_width   = 14,
  parameter int gpio_base      = 0,
  parameter int poll_period    = 1000,
  parameter int timeout_cycles = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [wb_adr_width-1:0]  wb_adr_o,
  output logic [wb_dat_width-1:0]  wb_dat_o,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic [wb_dat_width-1:0]  wb_dat_i,
  input  logic                     wb_ack_i,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_sel,
  input  logic [gpio_io_width-1:0] cmd_data,
  input  logic [gpio_io_width-1:0] irq_mask,
  output logic [gpio_io_width-1:0] gpio_state,
  output logic [gpio_io_width-1:0] change_mask,
  output logic                     irq,
  output logic                     err
);

  localparam int CNT_W = (poll_period > 1) ? $clog2(poll_period) : 1;
  localparam logic [CNT_W-1:0] POLL_RELOAD = CNT_W'(poll_period - 1);
  localparam logic [wb_adr_width-1:0] ADR_DATA = wb_adr_width'(gpio_base);
  localparam logic [wb_adr_width-1:0] ADR_OUT  = ADR_DATA | wb_adr_width'(1);
  localparam logic [wb_adr_width-1:0] ADR_DIR  = ADR_DATA | wb_adr_width'(2);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                   state, state_nxt;
  logic                     start_rd, start_wr, busy;
  logic                     alive;         // low during and until the first edge after reset
  logic                     poll_pending;
  logic                     last_write;    // previous transaction was a WRITE
  logic                     first_done;    // a read has completed since reset
  logic [CNT_W-1:0]         poll_cnt;
  logic                     timeout_hit;
  logic [gpio_io_width-1:0] rd_new, rd_change;
  logic                     unused_dat;

  assign busy      = (state != IDLE);
  assign rd_new    = wb_dat_i[gpio_io_width-1:0];
  assign rd_change = rd_new ^ gpio_state;
  assign unused_dat = ^wb_dat_i;
  assign wb_stb_o  = wb_cyc_o;

  // A pending poll beats a command only right after a WRITE, giving strict
  // alternation under continuous command pressure.
  assign cmd_ready = alive && (state == IDLE) && !(poll_pending && last_write);

  always_comb begin
    state_nxt = state;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_nxt = WRITE;
          start_wr  = 1'b1;
        end else if (poll_pending) begin
          state_nxt = READ;
          start_rd  = 1'b1;
        end
      end
      READ, WRITE: begin
        if (wb_ack_i || timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Poll timer: a second expiry while a poll is still pending is absorbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt     <= POLL_RELOAD;
      poll_pending <= 1'b0;
      alive        <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (poll_cnt == '0) begin
        poll_cnt     <= POLL_RELOAD;
        poll_pending <= 1'b1;
      end else begin
        poll_cnt <= poll_cnt - CNT_W'(1);
        if (start_rd) poll_pending <= 1'b0;
      end
    end
  end

  // Bus outputs and shadow state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cyc_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      last_write  <= 1'b0;
      first_done  <= 1'b0;
      gpio_state  <= '0;
      change_mask <= '0;
      irq         <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (start_wr) begin
        wb_cyc_o   <= 1'b1;
        wb_we_o    <= 1'b1;
        wb_adr_o   <= cmd_sel ? ADR_DIR : ADR_OUT;
        wb_dat_o   <= wb_dat_width'(cmd_data);
        last_write <= 1'b1;
      end else if (start_rd) begin
        wb_cyc_o   <= 1'b1;
        wb_we_o    <= 1'b0;
        wb_adr_o   <= ADR_DATA;
        last_write <= 1'b0;
      end else if (busy && wb_ack_i) begin
        wb_cyc_o <= 1'b0;
        wb_we_o  <= 1'b0;
        if (state == READ) begin
          gpio_state  <= rd_new;
          change_mask <= rd_change;
          // the first read after reset only seeds the shadow copy
          irq         <= first_done && |(rd_change & irq_mask);
          first_done  <= 1'b1;
        end
      end else if (timeout_hit) begin
        wb_cyc_o <= 1'b0;
        wb_we_o  <= 1'b0;
      end
    end
  end

`ifdef WB_GPIO_POLLER_TIMEOUT_EN
  localparam int TO_W = $clog2(timeout_cycles + 1);
  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // to_cnt holds the number of busy cycles already elapsed without ack
  assign timeout_hit = busy && !wb_ack_i && (to_cnt == TO_W'(timeout_cycles - 1));
  assign err         = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (!busy) to_cnt <= '0;
      else       to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  logic unused_to;
  assign unused_to   = (timeout_cycles != 0);
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_wb_gpio_poller.sv
module tb_wb_gpio_poller;

  localparam int GW   = 8;
  localparam int DW   = 16;
  localparam int AW   = 14;
  localparam int BASE = 'h120;
  localparam int POLL = 40;
  localparam int TO   = 15;
  localparam logic [AW-1:0] ADR_DATA = AW'(BASE);
  localparam logic [AW-1:0] ADR_OUT  = AW'(BASE + 1);
  localparam logic [AW-1:0] ADR_DIR  = AW'(BASE + 2);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic          wb_we_o, wb_cyc_o, wb_stb_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_sel = 1'b0;
  logic [GW-1:0] cmd_data = '0;
  logic [GW-1:0] irq_mask = '0;
  logic [GW-1:0] gpio_state, change_mask;
  logic          irq, err;

  // responder model state
  logic [GW-1:0]    pins = '0;
  logic [DW-GW-1:0] rd_hi = '0;
  logic             no_ack = 1'b0;
  int               wcnt = 0;
  logic [GW-1:0]    out_reg = '0, dir_reg = '0;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } txn_t;
  txn_t log_q[$];

  // reference model of the shadow register
  logic [GW-1:0] model_gpio = '0;
  bit            model_init = 0;

  int tests_run = 0;
  int tests_failed = 0;

  assign wb_dat_i = {rd_hi, pins};

  always #5 clk = ~clk;

  wb_gpio_poller #(
    .gpio_io_width(GW), .wb_dat_width(DW), .wb_adr_width(AW),
    .gpio_base(BASE), .poll_period(POLL), .timeout_cycles(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .irq_mask(irq_mask), .gpio_state(gpio_state), .change_mask(change_mask),
    .irq(irq), .err(err)
  );

  // GPIO responder: ack in the third cycle of a request, registers on writes
  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      log_q.push_back({wb_we_o, wb_adr_o, wb_dat_o});
      if (wb_we_o) begin
        if (wb_adr_o == ADR_OUT)      out_reg <= wb_dat_o[GW-1:0];
        else if (wb_adr_o == ADR_DIR) dir_reg <= wb_dat_o[GW-1:0];
      end
    end
    if (wb_cyc_o && wb_stb_o && !wb_ack_i && !no_ack) begin
      if (wcnt == 1) wb_ack_i <= 1'b1;
      wcnt <= wcnt + 1;
    end else begin
      wb_ack_i <= 1'b0;
      wcnt     <= 0;
    end
  end

  task automatic wait_read(output bit found);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (wb_cyc_o && !wb_we_o && wb_ack_i) begin
        @(posedge clk); #1;
        found = 1;
        break;
      end
    end
  endtask

  // Present a new pin value, wait for the next completed poll and return the
  // model's expectation for it.
  task automatic poll_once(input logic [GW-1:0] v, input logic [GW-1:0] m,
                           output bit found, output logic [GW-1:0] exp_chg,
                           output logic exp_irq);
    pins     = v;
    rd_hi    = (DW-GW)'($urandom);
    irq_mask = m;
    wait_read(found);
    exp_chg    = v ^ model_gpio;
    exp_irq    = model_init && ((exp_chg & m) != '0);
    model_gpio = v;
    model_init = 1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!wb_cyc_o) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, cmd_ready, gpio_state, change_mask, irq, err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: cyc=%b ready=%b adr=%h dat=%h gpio=%h chg=%h irq=%b err=%b, want all 0",
               wb_cyc_o, cmd_ready, wb_adr_o, wb_dat_o, gpio_state, change_mask, irq, err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_after_reset: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_first_poll();
    bit f; logic [GW-1:0] ec; logic ei;
    poll_once(8'h00, 8'hFF, f, ec, ei);
    tests_run++;
    if (!f || gpio_state !== 8'h00 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_poll: found=%0d gpio=%h irq=%b want gpio=00 irq=0", f, gpio_state, irq);
    end
    poll_once(8'h05, 8'hFF, f, ec, ei);
    tests_run++;
    if (!f || gpio_state !== 8'h05 || change_mask !== ec || irq !== ei) begin
      tests_failed++;
      $display("FAIL second_poll: gpio=%h chg=%h irq=%b want gpio=05 chg=%h irq=%b", gpio_state, change_mask, irq, ec, ei);
    end
    @(posedge clk); #1;
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_one_cycle: got %b want 0", irq);
    end
  endtask

  task automatic test_irq_mask();
    bit f; logic [GW-1:0] ec; logic ei;
    poll_once(8'h01, 8'h04, f, ec, ei);
    tests_run++;
    if (!f || change_mask !== ec || irq !== ei) begin
      tests_failed++;
      $display("FAIL mask_hit: chg=%h irq=%b want chg=%h irq=%b", change_mask, irq, ec, ei);
    end
    poll_once(8'h03, 8'h04, f, ec, ei);
    tests_run++;
    if (!f || change_mask !== ec || irq !== ei) begin
      tests_failed++;
      $display("FAIL mask_miss: chg=%h irq=%b want chg=%h irq=%b", change_mask, irq, ec, ei);
    end
  endtask

  task automatic test_random_polls();
    bit f; logic [GW-1:0] ec, v; logic ei;
    for (int i = 0; i < 8; i++) begin
      v = GW'($urandom);
      if ($urandom_range(3) == 0) v = model_gpio;
      poll_once(v, GW'($urandom), f, ec, ei);
      tests_run++;
      if (!f || gpio_state !== v || change_mask !== ec || irq !== ei) begin
        tests_failed++;
        $display("FAIL random_poll%0d: found=%0d gpio=%h chg=%h irq=%b want gpio=%h chg=%h irq=%b",
                 i, f, gpio_state, change_mask, irq, v, ec, ei);
      end
      @(posedge clk); #1;
      tests_run++;
      if (irq !== 1'b0) begin
        tests_failed++;
        $display("FAIL random_irq_drop%0d: got %b want 0", i, irq);
      end
    end
  endtask

  task automatic test_write();
    bit acc; int n, ready_bad;
    logic [GW-1:0] d;
    for (int k = 0; k < 2; k++) begin
      wait_idle();
      cmd_sel   = (k == 0);
      d         = (k == 0) ? 8'hA5 : GW'($urandom);
      cmd_data  = d;
      cmd_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 100; i++) begin
        if (cmd_ready) begin
          @(posedge clk); #1;
          acc = 1;
          break;
        end
        @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      tests_run++;
      if (!acc || {wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111 || wb_adr_o !== (k == 0 ? ADR_DIR : ADR_OUT)
          || wb_dat_o !== DW'(d) || cmd_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL write%0d_start: acc=%0d cyc/stb/we=%b%b%b adr=%h dat=%h ready=%b want 111 adr=%h dat=%h ready=0",
                 k, acc, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, cmd_ready,
                 (k == 0 ? ADR_DIR : ADR_OUT), DW'(d));
      end
      n = 0; ready_bad = 0;
      while (wb_cyc_o && n < 20) begin
        n++;
        if (cmd_ready) ready_bad++;
        @(posedge clk); #1;
      end
      tests_run++;
      if (n != 3 || ready_bad != 0 || wb_stb_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL write%0d_len: cyc_cycles=%0d ready_while_busy=%0d stb_after=%b want 3 0 0", k, n, ready_bad, wb_stb_o);
      end
      tests_run++;
      if ((k == 0 ? dir_reg : out_reg) !== d) begin
        tests_failed++;
        $display("FAIL write%0d_reg: got %h want %h", k, (k == 0 ? dir_reg : out_reg), d);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [GW:0] exp_q[$];
    bit acc; int wi, nreads, rr, exp_reads;
    logic [AW-1:0] ea;
    wait_idle();
    log_q.delete();
    cmd_sel   = 1'($urandom);
    cmd_data  = GW'($urandom);
    cmd_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      acc = cmd_ready;
      if (acc) exp_q.push_back({cmd_sel, cmd_data});
      @(posedge clk); #1;
      if (acc) begin
        cmd_sel  = 1'($urandom);
        cmd_data = GW'($urandom);
      end
    end
    cmd_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    wi = 0; nreads = 0; rr = 0;
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].we) begin
        if (wi < exp_q.size()) begin
          ea = exp_q[wi][GW] ? ADR_DIR : ADR_OUT;
          tests_run++;
          if (log_q[i].adr !== ea || log_q[i].dat !== DW'(exp_q[wi][GW-1:0])) begin
            tests_failed++;
            $display("FAIL b2b_write%0d: adr=%h dat=%h want adr=%h dat=%h", wi, log_q[i].adr, log_q[i].dat,
                     ea, DW'(exp_q[wi][GW-1:0]));
          end
        end
        wi++;
      end else begin
        nreads++;
        if (i > 0 && !log_q[i-1].we) rr++;
      end
    end
    exp_reads = 412 / POLL;
    tests_run++;
    if (wi != exp_q.size()) begin
      tests_failed++;
      $display("FAIL b2b_write_count: got %0d want %0d", wi, exp_q.size());
    end
    tests_run++;
    if (nreads < exp_reads - 1 || nreads > exp_reads + 1 || rr != 0) begin
      tests_failed++;
      $display("FAIL b2b_reads: reads=%0d adjacent_reads=%0d want %0d+-1 and 0", nreads, rr, exp_reads);
    end
  endtask

  task automatic test_timeout();
    int n, nerr;
    bit rose;
    logic [GW-1:0] chg_before;
    wait_idle();
    no_ack = 1'b1;
    chg_before = change_mask;
    rose = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (wb_cyc_o) begin rose = 1; break; end
    end
    tests_run++;
    if (!rose || wb_we_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_start: rose=%0d we=%b want 1 0", rose, wb_we_o);
    end
`ifdef WB_GPIO_POLLER_TIMEOUT_EN
    pins = ~model_gpio;
    n = 0; nerr = 0;
    while (wb_cyc_o && n < 60) begin
      n++;
      if (err) nerr++;
      @(posedge clk); #1;
    end
    if (err) nerr++;
    pins   = model_gpio;
    no_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (err) nerr++;
    end
    tests_run++;
    if (n != TO || nerr != 1) begin
      tests_failed++;
      $display("FAIL timeout_abort: cyc_cycles=%0d err_pulses=%0d want %0d 1", n, nerr, TO);
    end
    tests_run++;
    if (gpio_state !== model_gpio || change_mask !== chg_before) begin
      tests_failed++;
      $display("FAIL timeout_state: gpio=%h chg=%h want %h %h", gpio_state, change_mask, model_gpio, chg_before);
    end
`else
    n = 0; nerr = 0;
    while (wb_cyc_o && n < 40) begin
      n++;
      if (err) nerr++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (n != 40 || wb_cyc_o !== 1'b1 || nerr != 0) begin
      tests_failed++;
      $display("FAIL no_timeout: cyc_cycles=%0d cyc=%b err_pulses=%0d want 40 1 0", n, wb_cyc_o, nerr);
    end
    no_ack = 1'b0;
    wait_idle();
    tests_run++;
    if (wb_cyc_o !== 1'b0 || gpio_state !== model_gpio) begin
      tests_failed++;
      $display("FAIL stall_release: cyc=%b gpio=%h want 0 %h", wb_cyc_o, gpio_state, model_gpio);
    end
`endif
  endtask

  task automatic test_reset_mid_read();
    bit rose, f; logic [GW-1:0] ec, v; logic ei;
    wait_idle();
    rose = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (wb_cyc_o && !wb_we_o) begin rose = 1; break; end
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (!rose || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: rose=%0d cyc=%b stb=%b ready=%b want 0 0 0", rose, wb_cyc_o, wb_stb_o, cmd_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_gpio = '0;
    model_init = 0;
    v = GW'($urandom) | 8'h01;
    poll_once(v, 8'hFF, f, ec, ei);
    tests_run++;
    if (!f || gpio_state !== v || change_mask !== ec || irq !== 1'b0 || ei !== 1'b0) begin
      tests_failed++;
      $display("FAIL poll_after_reset: gpio=%h chg=%h irq=%b want gpio=%h chg=%h irq=0", gpio_state, change_mask, irq, v, ec);
    end
  endtask

  initial begin
    test_reset();
    test_first_poll();
    test_irq_mask();
    test_random_polls();
    test_write();
    test_back_to_back();
    test_timeout();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_gpio_poller.md
# wb_gpio_poller

Wishbone bus initiator that drives a GPIO responder on the shared Wishbone bus. It polls the responder's input-data register at a fixed period and keeps a shadowed copy of the pin state. It detects pin changes and raises a masked interrupt pulse. It also forwards output/direction writes from a simple valid/ready command port, so logic without bus access can control the GPIO bank.

## Interface
- gpio_io_width, 8: GPIO bank width; must be ≤ wb_dat_width.
- wb_dat_width, 16: Wishbone data width.
- wb_adr_width, 14: Wishbone address width.
- gpio_base, 0: responder base address; data = base+0, out = base+1, dir = base+2; base[1:0] must be 0.
- poll_period, 1000: clk cycles between poll starts; ≥ 8.
- timeout_cycles, 15: cycles without ack before abort; only used with timeout feature.

- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- wb_adr_o  out  wb_adr_width  transaction address.
- wb_dat_o  out  wb_dat_width  write data, cmd_data zero-extended.
- wb_we_o  out  1  1 = write.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe; always equal to wb_cyc_o.
- wb_dat_i  in  wb_dat_width  read data.
- wb_ack_i  in  1  responder acknowledge.
- cmd_valid  in  1  write request.
- cmd_ready  out  1  request accepted when valid & ready.
- cmd_sel  in  1  0 = output register (base+1), 1 = direction register (base+2).
- cmd_data  in  gpio_io_width  value to write.
- irq_mask  in  gpio_io_width  per-bit interrupt enable.
- gpio_state  out  gpio_io_width  last polled pin value.
- change_mask  out  gpio_io_width  bits that changed at the last poll.
- irq  out  1  one-cycle change pulse.
- err  out  1  one-cycle timeout pulse; constant 0 without the timeout feature.

## Operation
- The FSM has three states: IDLE, READ and WRITE. All outputs are registered.
- Poll counter:
  - Loads poll_period-1 at reset and decrements every cycle.
  - At 0 it sets poll_pending and reloads.
  - poll_pending clears when a READ starts.
  - A second expiry while pending is absorbed; no queueing.
- IDLE:
  - cmd_ready = 1 only in IDLE, and not while rst is asserted.
  - A command is accepted on valid & ready. The FSM moves to WRITE and latches sel and data.
  - If poll_pending, the FSM moves to READ.
- Arbitration when a command and poll_pending coincide:
  - The command wins unless the previous transaction was a WRITE; then READ wins and cmd_ready is held 0 that cycle.
  - Result: strict alternation, no starvation.
- READ/WRITE:
  - cyc = stb = 1 and the address is driven. we = 1 in WRITE.
  - All bus outputs stay stable until ack.
- On wb_ack_i:
  - cyc, stb and we drop at that edge. The FSM returns to IDLE.
  - READ only: new = wb_dat_i[gpio_io_width-1:0]; change_mask <= new ^ gpio_state; gpio_state <= new.
  - READ only: irq pulses if |(change & irq_mask) and this is not the first completed read since reset. The first read only initialises gpio_state.
- wb_ack_i outside READ/WRITE is ignored.
- Upper bits of wb_dat_i are ignored.

## Timing
- Reset value: every output is 0. cmd_ready rises the first cycle after rst deasserts. rst mid-transaction drops cyc/stb immediately.
- Accept edge → cyc/stb high from the next cycle.
- Against the GPIO responder, ack arrives 2 cycles after stb rises. Transaction = 3 cycles of cyc, plus 1 mandatory IDLE cycle before the next transaction.
- gpio_state, change_mask and irq update on the ack edge; irq is visible for the following cycle only.
- stb never stays high on the cycle after ack, so the responder does not see a repeated request.

## Configuration
- WB_GPIO_POLLER_TIMEOUT_EN defined:
  - A cycle counter runs in READ/WRITE.
  - If timeout_cycles cycles pass without ack, cyc/stb drop, err pulses 1 cycle and the FSM returns to IDLE.
  - On a READ abort, gpio_state, change_mask and irq are unchanged. The aborted command is dropped.
- Undefined: the FSM waits indefinitely for ack; err is tied 0 and the counter is not built.

## Test plan
- Reset, then the responder returns 0x00 and next 0x05 with irq_mask = 0xFF:
  - First poll → gpio_state = 0x00, no irq.
  - Second poll → gpio_state = 0x05, change_mask = 0x05, irq for 1 cycle.
- irq_mask = 0x04 and input changes 0x05 → 0x01: change_mask = 0x04, irq pulses. Input changes 0x01 → 0x03: change_mask = 0x02, no irq.
- cmd_sel = 1, cmd_data = 0xA5: bus write to base+2 with wb_dat_o = 0x00A5 and we = 1; cmd_ready = 0 until IDLE; cyc is high for exactly 3 cycles.
- cmd_valid held high continuously with poll_pending set: transactions alternate WRITE/READ; no poll is skipped beyond one absorbed expiry.
- With the timeout macro, responder never acks and timeout_cycles = 15: cyc drops after 15 cycles, err pulses once, gpio_state is unchanged. Without the macro: cyc stays high.
- Assert rst during READ: cyc/stb/cmd_ready go 0 asynchronously. After release, the first poll completes without irq.
